// File: rtl/colour_output_stage.sv
// rtl/colour_output_stage.sv - registered colour back-end: themed palette lookup, frame-synced theme switch, fg/bg flash
module colour_output_stage #(
    parameter int CW           = 2,
    parameter int NUM_THEMES   = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PERIOD = 2,
    localparam int TW          = $clog2(NUM_THEMES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            video_active,
    input  logic            frame_end,
    input  logic            pixel_value,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic [TW-1:0]   theme_sel,
    input  logic            flash_trig,
    input  logic            pal_wr_en,
    input  logic [TW:0]     pal_wr_addr,
    input  logic [3*CW-1:0] pal_wr_data,
    output logic            pal_wr_ready,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            hsync_out,
    output logic            vsync_out,
    output logic            flash_active
);

    localparam int PIXW = 3 * CW;
    localparam int RW   = $clog2(FLASH_FRAMES + 1);
    localparam int PW   = $clog2(FLASH_PERIOD + 1);
    localparam logic [TW:0] NT_L = (TW + 1)'(NUM_THEMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    flash_state_t    state_q, state_d;
    logic [RW-1:0]   remain_q, remain_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [TW-1:0]   theme_q, theme_d;
    logic [PIXW-1:0] rgb_q, rgb_d;
    logic            hsync_q, vsync_q;
    logic [PIXW-1:0] pal_q [NUM_THEMES][2];

    logic            swap;
    logic            pix_sel;
    logic [PIXW-1:0] colour;
    logic [TW-1:0]   wr_theme;
    logic            wr_sel;
    logic            wr_fire;

    function automatic logic [PIXW-1:0] default_bg(input int t);
        logic [CW-1:0] f;
        logic [CW-1:0] z;
        f = {CW{1'b1}};
        z = '0;
        case (t)
            0:       default_bg = {f, z, z};
            1:       default_bg = {z, f, z};
            2:       default_bg = {z, z, f};
            3:       default_bg = {f, z, f};
            default: default_bg = '0;
        endcase
    endfunction

    assign pal_wr_ready = ~video_active;
    assign wr_theme     = pal_wr_addr[TW:1];
    assign wr_sel       = pal_wr_addr[0];
    // Out-of-range theme addresses still complete the handshake, they just store nothing.
    assign wr_fire      = pal_wr_en & pal_wr_ready & ({1'b0, wr_theme} < NT_L);

    assign swap    = (state_q == FLASH_ON);
    assign pix_sel = pixel_value ^ swap;
    assign colour  = pal_q[theme_q][pix_sel];

    always_comb begin
        rgb_d   = video_active ? colour : '0;
        theme_d = theme_q;
        if (frame_end && ({1'b0, theme_sel} < NT_L)) begin
            theme_d = theme_sel;
        end
    end

    // A trigger always wins over a coincident frame_end, so that frame is not counted.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        phase_d  = phase_q;
        if (flash_trig) begin
            state_d  = FLASH_ON;
            remain_d = RW'(FLASH_FRAMES);
            phase_d  = PW'(FLASH_PERIOD);
        end else if (frame_end && (state_q != IDLE)) begin
            if (remain_q == RW'(1)) begin
                state_d  = IDLE;
                remain_d = '0;
                phase_d  = '0;
            end else begin
                remain_d = remain_q - RW'(1);
                if (phase_q == PW'(1)) begin
                    state_d = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                    phase_d = PW'(FLASH_PERIOD);
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            phase_q  <= '0;
            theme_q  <= '0;
            rgb_q    <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            phase_q  <= phase_d;
            theme_q  <= theme_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THEMES; t++) begin
                pal_q[t][0] <= default_bg(t);
                pal_q[t][1] <= {PIXW{1'b1}};
            end
        end else if (wr_fire) begin
            pal_q[wr_theme][wr_sel] <= pal_wr_data;
        end
    end

    assign R            = rgb_q[3*CW-1:2*CW];
    assign G            = rgb_q[2*CW-1:CW];
    assign B            = rgb_q[CW-1:0];
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign flash_active = (state_q != IDLE);

endmodule

// File: tb/tb_colour_output_stage.sv
// tb/tb_colour_output_stage.sv - scoreboard bench for colour_output_stage against a frame-level reference model
module tb_colour_output_stage;

    localparam int CW = 2;
    localparam int NT = 4;
    localparam int FF = 8;
    localparam int FP = 2;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          video_active = 1'b0;
    logic          frame_end = 1'b0;
    logic          pixel_value = 1'b0;
    logic          hsync_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic [TW-1:0] theme_sel = '0;
    logic          flash_trig = 1'b0;
    logic          pal_wr_en = 1'b0;
    logic [TW:0]   pal_wr_addr = '0;
    logic [5:0]    pal_wr_data = '0;
    logic          pal_wr_ready;
    logic [CW-1:0] R, G, B;
    logic          hsync_out, vsync_out, flash_active;

    colour_output_stage #(.CW(CW), .NUM_THEMES(NT), .FLASH_FRAMES(FF), .FLASH_PERIOD(FP)) dut (
        .clk(clk), .rst_n(rst_n), .video_active(video_active), .frame_end(frame_end),
        .pixel_value(pixel_value), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .theme_sel(theme_sel), .flash_trig(flash_trig), .pal_wr_en(pal_wr_en),
        .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data), .pal_wr_ready(pal_wr_ready),
        .R(R), .G(G), .B(B), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .flash_active(flash_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       fa;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [5:0] m_pal [NT][2];
    int         m_theme;
    bit         m_flash;
    int         m_elapsed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) m_pal[t][1] = 6'b11_11_11;
        m_pal[0][0] = 6'b11_00_00;
        m_pal[1][0] = 6'b00_11_00;
        m_pal[2][0] = 6'b00_00_11;
        m_pal[3][0] = 6'b11_00_11;
        m_theme   = 0;
        m_flash   = 0;
        m_elapsed = 0;
    endtask

    // One clock of stimulus: drive at negedge, predict the registered response, then advance the model.
    task automatic step(input bit va = 1, input bit fe = 0, input bit px = 0, input bit hs = 0,
                        input bit vs = 0, input bit ft = 0, input bit we = 0,
                        input logic [TW-1:0] ts = '0, input logic [TW:0] wa = '0,
                        input logic [5:0] wd = '0);
        exp_t e;
        bit   swapped;
        @(negedge clk);
        video_active = va; frame_end = fe; pixel_value = px; hsync_in = hs; vsync_in = vs;
        flash_trig = ft; pal_wr_en = we; theme_sel = ts; pal_wr_addr = wa; pal_wr_data = wd;
        #1 check("pal_wr_ready", {31'd0, pal_wr_ready}, {31'd0, !va});
        swapped = m_flash && (((m_elapsed / FP) % 2) == 0);
        e.rgb = va ? m_pal[m_theme][px ^ swapped] : 6'd0;
        e.hs  = hs;
        e.vs  = vs;
        if (we && !va && (int'(wa[TW:1]) < NT)) m_pal[wa[TW:1]][wa[0]] = wd;
        if (fe && (int'(ts) < NT)) m_theme = int'(ts);
        if (ft) begin
            m_flash = 1; m_elapsed = 0;
        end else if (fe && m_flash) begin
            m_elapsed++;
            if (m_elapsed >= FF) m_flash = 0;
        end
        e.fa = m_flash;
        q.push_back(e);
    endtask

    task automatic expect_now(input string name, input logic [5:0] rgb);
        @(posedge clk);
        #2 check(name, {26'd0, R, G, B}, {26'd0, rgb});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_rgb", {26'd0, R, G, B}, 32'd0);
        check("reset_flash", {31'd0, flash_active}, 32'd0);
        check("reset_sync", {30'd0, hsync_out, vsync_out}, 32'd0);
        model_reset();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rgb", {26'd0, R, G, B}, {26'd0, e.rgb});
                check("hsync_out", {31'd0, hsync_out}, {31'd0, e.hs});
                check("vsync_out", {31'd0, vsync_out}, {31'd0, e.vs});
                check("flash_active", {31'd0, flash_active}, {31'd0, e.fa});
            end
        end
    end

    initial begin : stimulus
        model_reset();
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #12;
        check("por_rgb", {26'd0, R, G, B}, 32'd0);
        check("por_sync", {30'd0, hsync_out, vsync_out}, 32'd0);
        check("por_flash", {31'd0, flash_active}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic mapping and sync retiming
        step(.px(0), .hs(1));  expect_now("t1_bg", 6'b11_00_00);
        step(.px(1), .vs(1));  expect_now("t1_fg", 6'b11_11_11);
        step(.va(0), .px(1), .hs(1), .vs(1)); expect_now("t1_blank", 6'd0);

        // theme switch waits for frame_end
        step(.px(0), .ts(2));  expect_now("t2_hold", 6'b11_00_00);
        step(.px(0), .ts(2), .fe(1));
        step(.px(0), .ts(0));  expect_now("t2_new", 6'b00_00_11);
        step(.va(0), .fe(1), .ts(0));

        // palette write gated by video_active
        step(.va(1), .we(1), .wa(3'b000), .wd(6'b01_01_01));
        step(.px(0));          expect_now("t3_nowrite", 6'b11_00_00);
        step(.va(0), .we(1), .wa(3'b000), .wd(6'b01_01_01));
        step(.px(0));          expect_now("t3_write", 6'b01_01_01);

        // full flash from IDLE
        step(.ft(1));
        for (int f = 1; f <= FF; f++) begin
            for (int p = 0; p < 3; p++) step(.px(p[0]));
            step(.va(0), .fe(1));
        end
        step(.px(0));
        check("t4_done", {31'd0, flash_active}, 32'd0);

        // retrigger mid-flash and trigger coincident with frame_end
        step(.ft(1));
        for (int f = 0; f < 4; f++) begin step(.px(0)); step(.va(0), .fe(1)); end
        step(.ft(1)); step(.px(0));
        for (int f = 0; f < 3; f++) begin step(.px(0)); step(.va(0), .fe(1)); end
        step(.va(0), .fe(1), .ft(1));
        for (int f = 0; f < FF; f++) begin step(.px(0)); step(.va(0), .fe(1)); end
        step(.px(0));

        // reset mid-flash after a palette write and theme change
        step(.va(0), .we(1), .wa(3'b001), .wd(6'b10_10_10));
        step(.va(0), .fe(1), .ts(3));
        step(.ft(1)); step(.px(1));
        do_reset();
        step(.px(0)); expect_now("t6_bg", 6'b11_00_00);
        step(.px(1)); expect_now("t6_fg", 6'b11_11_11);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit va;
            va = ($urandom_range(0, 3) != 0);
            step(.va(va), .fe($urandom_range(0, 5) == 0), .px($urandom_range(0, 1) == 1),
                 .hs($urandom_range(0, 1) == 1), .vs($urandom_range(0, 1) == 1),
                 .ft($urandom_range(0, 60) == 0), .we($urandom_range(0, 2) == 0),
                 .ts(TW'($urandom_range(0, NT - 1))), .wa(3'($urandom_range(0, 7))),
                 .wd(6'($urandom_range(0, 63))));
            if (i == 1500) do_reset();
        end
        step(.va(0));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
